// File: rtl/tseq_pkg.sv
// Shared definitions for the 6502C T-state sequencer: interrupt source codes,
// the T1 one-hot constant, the injected opcode and an instruction-length clamp.
package tseq_pkg;

    typedef enum logic [1:0] {
        INT_NONE = 2'b00,
        INT_IRQ  = 2'b01,
        INT_NMI  = 2'b10,
        INT_RST  = 2'b11
    } int_src_t;

    localparam logic [31:0] T_ONE      = 32'd1;
    localparam logic [7:0]  BRK_OPCODE = 8'h00;

    function automatic int clamp_len(input int raw, input int lo, input int hi);
        if (raw < lo) return lo;
        if (raw > hi) return hi;
        return raw;
    endfunction

endpackage

// File: rtl/int_arb.sv
// Interrupt arbiter: NMI rising-edge latch, IRQ masking and NMI > IRQ priority.
// Defining TSEQ_IRQ_SYNC_EN inserts two-flop synchronisers on nmi and irq.
module int_arb
    import tseq_pkg::*;
#(
    parameter int NUM_IRQ = 2
) (
    input  logic                       phi1,
    input  logic                       rst,
    input  logic                       nmi,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic                       i_flag,
    input  logic                       accept,
    output logic                       pending,
    output logic [1:0]                 src,
    output logic [$clog2(NUM_IRQ)-1:0] id
);
    localparam int ID_W = $clog2(NUM_IRQ);

    logic               nmi_s;
    logic [NUM_IRQ-1:0] irq_s;

`ifdef TSEQ_IRQ_SYNC_EN
    logic [1:0]         nmi_sync_reg;
    logic [NUM_IRQ-1:0] irq_sync1_reg;
    logic [NUM_IRQ-1:0] irq_sync2_reg;

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            nmi_sync_reg  <= '0;
            irq_sync1_reg <= '0;
            irq_sync2_reg <= '0;
        end else begin
            nmi_sync_reg  <= {nmi_sync_reg[0], nmi};
            irq_sync1_reg <= irq;
            irq_sync2_reg <= irq_sync1_reg;
        end
    end

    assign nmi_s = nmi_sync_reg[1];
    assign irq_s = irq_sync2_reg;
`else
    assign nmi_s = nmi;
    assign irq_s = irq;
`endif

    logic               nmi_prev_reg;
    logic               nmi_latch_reg;
    logic               nmi_latch_next;
    logic [NUM_IRQ-1:0] irq_masked;
    logic [ID_W-1:0]    id_sel;

    // A fresh edge arriving in the acceptance cycle survives the clear.
    assign nmi_latch_next = (nmi_latch_reg && !accept) || (nmi_s && !nmi_prev_reg);

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            nmi_prev_reg  <= 1'b0;
            nmi_latch_reg <= 1'b0;
        end else begin
            nmi_prev_reg  <= nmi_s;
            nmi_latch_reg <= nmi_latch_next;
        end
    end

    assign irq_masked = irq_s & {NUM_IRQ{~i_flag}};

    always_comb begin
        id_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_masked[i]) id_sel = ID_W'(i);
        end
    end

    always_comb begin
        pending = nmi_latch_reg || (|irq_masked);
        src     = INT_NONE;
        id      = '0;
        if (nmi_latch_reg) begin
            src = INT_NMI;
        end else if (|irq_masked) begin
            src = INT_IRQ;
            id  = id_sel;
        end
    end

endmodule

// File: rtl/tstate_seq.sv
// One-hot T-state sequencer with IR latch, SYNC and interrupt injection (opcode 00).
// Optional input synchronisers inside int_arb are enabled by TSEQ_IRQ_SYNC_EN.
module tstate_seq
    import tseq_pkg::*;
#(
    parameter int T_WIDTH = 7,
    parameter int NUM_IRQ = 2,
    parameter int BRK_LEN = 7
) (
    input  logic                       phi1,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       nmi,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic                       i_flag,
    input  logic [7:0]                 opcode_in,
    input  logic [2:0]                 cyc_len,
    input  logic                       ext_cycle,
    output logic [T_WIDTH-1:0]         t_state,
    output logic                       sync,
    output logic [7:0]                 opcode,
    output logic                       force_brk,
    output logic [1:0]                 int_src,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    output logic                       instr_done
);
    localparam int LW   = $clog2(T_WIDTH + 1);
    localparam int ID_W = $clog2(NUM_IRQ);

    logic [T_WIDTH-1:0] t_state_reg, t_state_next;
    logic [LW-1:0]      len_reg, len_next, len_eff;
    logic [7:0]         opcode_reg, opcode_next;
    logic               force_brk_reg, force_brk_next;
    int_src_t           int_src_reg, int_src_next;
    logic [ID_W-1:0]    irq_id_reg, irq_id_next;
    logic               sync_reg, sync_next;
    logic [T_WIDTH-1:0] last_mask;
    logic               at_last;
    logic               accept;
    logic               arb_pending;
    logic [1:0]         arb_src;
    logic [ID_W-1:0]    arb_id;
    int                 len_base;
    int                 len_sum;

    int_arb #(.NUM_IRQ(NUM_IRQ)) u_int_arb (
        .phi1    (phi1),
        .rst     (rst),
        .nmi     (nmi),
        .irq     (irq),
        .i_flag  (i_flag),
        .accept  (accept),
        .pending (arb_pending),
        .src     (arb_src),
        .id      (arb_id)
    );

    // In T2 the length comes straight from predecode so a 2-cycle op can end there.
    always_comb begin
        len_base = int'(len_reg);
        if (force_brk_reg)
            len_base = BRK_LEN;
        else if (t_state_reg[1])
            len_base = clamp_len(int'(cyc_len), 2, T_WIDTH);
        len_sum = len_base;
        if (ext_cycle && !force_brk_reg && !t_state_reg[0])
            len_sum = clamp_len(len_base + 1, 2, T_WIDTH);
        len_eff = LW'(len_sum);
    end

    genvar gi;
    for (gi = 0; gi < T_WIDTH; gi++) begin : g_last
        assign last_mask[gi] = (len_eff == LW'(gi + 1));
    end

    assign at_last    = |(t_state_reg & last_mask);
    assign accept     = rdy && at_last;
    assign instr_done = accept;

    always_comb begin
        t_state_next   = t_state_reg;
        len_next       = len_reg;
        opcode_next    = opcode_reg;
        force_brk_next = force_brk_reg;
        int_src_next   = int_src_reg;
        irq_id_next    = irq_id_reg;
        sync_next      = sync_reg;
        if (rdy) begin
            len_next     = len_eff;
            t_state_next = at_last ? T_ONE[T_WIDTH-1:0] : (t_state_reg << 1);
            sync_next    = t_state_next[0];
            if (t_state_reg[0])
                opcode_next = force_brk_reg ? BRK_OPCODE : opcode_in;
            if (at_last) begin
                force_brk_next = arb_pending;
                int_src_next   = arb_pending ? int_src_t'(arb_src) : INT_NONE;
                irq_id_next    = arb_pending ? arb_id : '0;
            end
        end
    end

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            t_state_reg   <= T_ONE[T_WIDTH-1:0];
            len_reg       <= LW'(BRK_LEN);
            opcode_reg    <= BRK_OPCODE;
            force_brk_reg <= 1'b1;
            int_src_reg   <= INT_RST;
            irq_id_reg    <= '0;
            sync_reg      <= 1'b0;
        end else begin
            t_state_reg   <= t_state_next;
            len_reg       <= len_next;
            opcode_reg    <= opcode_next;
            force_brk_reg <= force_brk_next;
            int_src_reg   <= int_src_next;
            irq_id_reg    <= irq_id_next;
            sync_reg      <= sync_next;
        end
    end

    assign t_state   = t_state_reg;
    assign sync      = sync_reg;
    assign opcode    = opcode_reg;
    assign force_brk = force_brk_reg;
    assign int_src   = int_src_reg;
    assign irq_id    = irq_id_reg;

endmodule

// File: tb/tb_tstate_seq.sv
// Randomised bench for tstate_seq: an instruction-level model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_tstate_seq;
    localparam int T_WIDTH = 7;
    localparam int NUM_IRQ = 2;
    localparam int BRK_LEN = 7;
    localparam int NCYC    = 3000;

    logic       phi1 = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b1;
    logic       nmi = 1'b0;
    logic [1:0] irq = 2'b00;
    logic       i_flag = 1'b1;
    logic [7:0] opcode_in = 8'h00;
    logic [2:0] cyc_len = 3'd2;
    logic       ext_cycle = 1'b0;

    logic [6:0] t_state;
    logic       sync;
    logic [7:0] opcode;
    logic       force_brk;
    logic [1:0] int_src;
    logic [0:0] irq_id;
    logic       instr_done;

    typedef struct packed {
        logic [6:0] t;
        logic       sync;
        logic [7:0] op;
        logic       fb;
        logic [1:0] src;
        logic [0:0] id;
        logic       done;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    always #5 phi1 = ~phi1;

    tstate_seq #(.T_WIDTH(T_WIDTH), .NUM_IRQ(NUM_IRQ), .BRK_LEN(BRK_LEN)) dut (
        .phi1       (phi1),
        .rst        (rst),
        .rdy        (rdy),
        .nmi        (nmi),
        .irq        (irq),
        .i_flag     (i_flag),
        .opcode_in  (opcode_in),
        .cyc_len    (cyc_len),
        .ext_cycle  (ext_cycle),
        .t_state    (t_state),
        .sync       (sync),
        .opcode     (opcode),
        .force_brk  (force_brk),
        .int_src    (int_src),
        .irq_id     (irq_id),
        .instr_done (instr_done)
    );

    // Reference model: position within the current sequence as an integer count.
    int       m_cyc, m_len, m_len_eff, m_src, m_id;
    bit       m_int, m_fresh, m_done, m_nmi_pend, m_nmi_prev;
    logic [7:0] m_op;
    int       rst_left = 0;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_cyc = 1; m_len = BRK_LEN; m_int = 1'b1; m_src = 3; m_id = 0;
        m_op = 8'h00; m_fresh = 1'b1; m_nmi_pend = 1'b0; m_nmi_prev = 1'b0;
    endtask

    task automatic model_expect();
        obs_t e;
        int   base;
        if (m_int)           base = BRK_LEN;
        else if (m_cyc == 2) base = clampi(int'(cyc_len), 2, T_WIDTH);
        else                 base = m_len;
        if (!m_int && m_cyc >= 2 && ext_cycle && base < T_WIDTH) base = base + 1;
        m_len_eff = base;
        m_done    = rdy && (m_cyc == base);
        e.t    = 7'(1 << (m_cyc - 1));
        e.sync = (m_cyc == 1) && !m_fresh;
        e.op   = m_op;
        e.fb   = m_int;
        e.src  = 2'(m_src);
        e.id   = 1'(m_id);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        bit took_nmi;
        took_nmi = 1'b0;
        if (rdy) begin
            if (m_cyc == 1) m_op = m_int ? 8'h00 : opcode_in;
            m_len   = m_len_eff;
            m_fresh = 1'b0;
            if (m_done) begin
                if (m_nmi_pend) begin
                    m_int = 1'b1; m_src = 2; m_id = 0; took_nmi = 1'b1;
                end else if (!i_flag && irq != 2'b00) begin
                    m_int = 1'b1; m_src = 1; m_id = 0;
                    for (int i = NUM_IRQ - 1; i >= 0; i--) if (irq[i]) m_id = i;
                end else begin
                    m_int = 1'b0; m_src = 0; m_id = 0;
                end
                m_cyc = 1;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end
        m_nmi_pend = (m_nmi_pend && !took_nmi) || (nmi && !m_nmi_prev);
        m_nmi_prev = nmi;
    endtask

    task automatic randomize_inputs(input int c);
        int ph;
        ph = c / 500;
        if (c < 2) begin
            rst = 1'b1;
        end else begin
            if (ph >= 4 && rst_left == 0 && $urandom_range(119) == 0)
                rst_left = $urandom_range(1, 2);
            rst = (rst_left != 0);
            if (rst_left != 0) rst_left = rst_left - 1;
        end
        rdy       = (ph >= 3) ? ($urandom_range(3) != 0) : 1'b1;
        ext_cycle = ($urandom_range(5) == 0);
        cyc_len   = 3'($urandom_range(7));
        opcode_in = 8'($urandom);
        if (ph == 0) irq = 2'b00;
        else if ($urandom_range(19) == 0) irq = 2'($urandom_range(3));
        if ($urandom_range(14) == 0) i_flag = ~i_flag;
        if (ph < 2) nmi = 1'b0;
        else if ($urandom_range(11) == 0) nmi = ~nmi;
    endtask

    initial begin : driver
        model_reset();
        repeat (2) @(posedge phi1);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge phi1);
            #1;
            if (!rst) model_step();
            randomize_inputs(c);
            if (rst) model_reset();
            model_expect();
        end
        @(negedge phi1);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        checks++;
        if (done_seen < 100) begin
            errors++;
            $display("FAIL activity: %0d instruction boundaries seen, required >= 100", done_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(negedge phi1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {t_state, sync, opcode, force_brk, int_src, irq_id, instr_done};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got t_state=%b sync=%b op=%02h fb=%b src=%b id=%b done=%b required t_state=%b sync=%b op=%02h fb=%b src=%b id=%b done=%b",
                             $time, g.t, g.sync, g.op, g.fb, g.src, g.id, g.done,
                             e.t, e.sync, e.op, e.fb, e.src, e.id, e.done);
                end
                if (g.done === 1'b1) begin
                    done_seen++;
                    $display("instr end t=%0t op=%02h force_brk=%b int_src=%b irq_id=%b",
                             $time, g.op, g.fb, g.src, g.id);
                end
            end
        end
    end

endmodule
